// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs, state codes,
// select encodings and the instruction-class flag bundle.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;

  localparam logic [1:0] A3_RT  = 2'b00;
  localparam logic [1:0] A3_RD  = 2'b01;
  localparam logic [1:0] A3_RA  = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

  localparam logic [1:0] ALUB_RT  = 2'b00;
  localparam logic [1:0] ALUB_IMM = 2'b01;
  localparam logic [1:0] ALUB_LUI = 2'b10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_RS  = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;

  typedef struct packed {
    logic is_r;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_jal;
    logic is_jr;
    logic is_nop;
    logic is_illegal;
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class flags.
// Exactly one flag is set for any input; anything unrecognised lands in is_illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB: cls.is_r       = 1'b1;
          F_JR:         cls.is_jr      = 1'b1;
          F_SLL:        cls.is_nop     = 1'b1;
          default:      cls.is_illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.is_ori     = 1'b1;
      OP_LUI:  cls.is_lui     = 1'b1;
      OP_LW:   cls.is_lw      = 1'b1;
      OP_SW:   cls.is_sw      = 1'b1;
      OP_BEQ:  cls.is_beq     = 1'b1;
      OP_JAL:  cls.is_jal     = 1'b1;
      default: cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences PC/IR/GRF/ALU/DM, drives mux selects and
// write enables, and counts retired instructions.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               reg_we,
  output logic               mem_we,
  output logic [1:0]         a3_sel,
  output logic [1:0]         wd_sel,
  output logic [1:0]         alu_b_sel,
  output logic [1:0]         npc_sel,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  cls_t       cls;
  logic [2:0] nxt;
  logic       retire;
  logic       pc_we_c, ir_we_c, reg_we_c, mem_we_c, ext_op_c, illegal_c;
  logic [1:0] a3_c, wd_c, alub_c, npc_c;
  logic [2:0] aluop_c;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  always_comb begin
    nxt       = S_FETCH;
    retire    = 1'b0;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    reg_we_c  = 1'b0;
    mem_we_c  = 1'b0;
    ext_op_c  = 1'b0;
    illegal_c = 1'b0;
    a3_c      = A3_RT;
    wd_c      = WD_ALU;
    alub_c    = ALUB_RT;
    npc_c     = NPC_PC4;
    aluop_c   = ALU_ADD;

    // ALU-side controls stay stable from EXEC through MEM/WB so the datapath can rely on them.
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      if (cls.is_beq) begin
        aluop_c  = ALU_SUB;
        ext_op_c = 1'b1;
      end else if (cls.is_ori) begin
        aluop_c = ALU_OR;
        alub_c  = ALUB_IMM;
      end else if (cls.is_lui) begin
        alub_c = ALUB_LUI;
      end else if (cls.is_lw || cls.is_sw) begin
        alub_c   = ALUB_IMM;
        ext_op_c = 1'b1;
      end else if (cls.is_r && funct == F_SUB) begin
        aluop_c = ALU_SUB;
      end
    end

    case (state)
      S_FETCH: begin
        ir_we_c = mem_ready;
        pc_we_c = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (cls.is_jal) begin
          reg_we_c = 1'b1;
          a3_c     = A3_RA;
          wd_c     = WD_PC;
          pc_we_c  = 1'b1;
          npc_c    = NPC_J;
          retire   = 1'b1;
        end else if (cls.is_jr) begin
          pc_we_c = 1'b1;
          npc_c   = NPC_RS;
          retire  = 1'b1;
        end else if (cls.is_nop || cls.is_illegal) begin
          illegal_c = cls.is_illegal;
          retire    = 1'b1;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.is_beq) begin
          pc_we_c = zero;
          npc_c   = NPC_BR;
          retire  = 1'b1;
        end else if (cls.is_lw || cls.is_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_we_c = cls.is_sw;
        if (!mem_ready) nxt = S_MEM;
        else if (cls.is_sw) retire = 1'b1;
        else nxt = S_WB;
      end
      S_WB: begin
        reg_we_c = 1'b1;
        retire   = 1'b1;
        if (cls.is_r) a3_c = A3_RD;
        if (cls.is_lw) wd_c = WD_DM;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Gating by reset keeps a mid-instruction reset from issuing any partial write.
  assign pc_we     = pc_we_c   & ~reset;
  assign ir_we     = ir_we_c   & ~reset;
  assign reg_we    = reg_we_c  & ~reset;
  assign mem_we    = mem_we_c  & ~reset;
  assign illegal   = illegal_c & ~reset;
  assign ext_op    = ext_op_c  & ~reset;
  assign a3_sel    = reset ? 2'b00 : a3_c;
  assign wd_sel    = reset ? 2'b00 : wd_c;
  assign alu_b_sel = reset ? 2'b00 : alub_c;
  assign npc_sel   = reset ? 2'b00 : npc_c;
  assign alu_op    = reset ? '0 : ALUOP_W'(aluop_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through the FSM and checks
// outputs against hand-computed values with immediate assertions.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_we, ir_we, reg_we, mem_we, ext_op, illegal;
  logic [1:0]  a3_sel, wd_sel, alu_b_sel, npc_sel;
  logic [2:0]  alu_op, state;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  mc_ctrl #(.CNT_W(32), .ALUOP_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .reg_we    (reg_we),
    .mem_we    (mem_we),
    .a3_sel    (a3_sel),
    .wd_sel    (wd_sel),
    .alu_b_sel (alu_b_sel),
    .npc_sel   (npc_sel),
    .ext_op    (ext_op),
    .alu_op    (alu_op),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_ir_we", {31'd0, ir_we}, 32'd0);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);

    // add 0x00851020
    reset = 1'b0; #1;
    chk("add_fetch_state", {29'd0, state}, 32'd0);
    chk("add_fetch_ir_we", {31'd0, ir_we}, 32'd1);
    chk("add_fetch_pc_we", {31'd0, pc_we}, 32'd1);
    chk("add_fetch_npc", {30'd0, npc_sel}, 32'd0);
    tick();
    chk("add_dec_state", {29'd0, state}, 32'd1);
    chk("add_dec_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    chk("add_exec_state", {29'd0, state}, 32'd2);
    chk("add_exec_alub", {30'd0, alu_b_sel}, 32'd0);
    chk("add_exec_aluop", {29'd0, alu_op}, 32'd0);
    tick();
    chk("add_wb_state", {29'd0, state}, 32'd4);
    chk("add_wb_reg_we", {31'd0, reg_we}, 32'd1);
    chk("add_wb_a3", {30'd0, a3_sel}, 32'd1);
    chk("add_wb_wd", {30'd0, wd_sel}, 32'd0);
    tick();
    chk("add_done_state", {29'd0, state}, 32'd0);
    chk("add_retired", retired, 32'd1);

    // lw 0x8C880004, DM stalls for three MEM cycles
    instr(6'h23, 6'h04);
    tick(); tick();
    chk("lw_exec_alub", {30'd0, alu_b_sel}, 32'd1);
    chk("lw_exec_ext", {31'd0, ext_op}, 32'd1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_mem_wait_state", {29'd0, state}, 32'd3);
      chk("lw_mem_wait_mem_we", {31'd0, mem_we}, 32'd0);
    end
    tick();
    mem_ready = 1'b1; #1;
    chk("lw_mem4_state", {29'd0, state}, 32'd3);
    chk("lw_mem4_alub", {30'd0, alu_b_sel}, 32'd1);
    tick();
    chk("lw_wb_state", {29'd0, state}, 32'd4);
    chk("lw_wb_a3", {30'd0, a3_sel}, 32'd0);
    chk("lw_wb_wd", {30'd0, wd_sel}, 32'd1);
    chk("lw_wb_reg_we", {31'd0, reg_we}, 32'd1);
    tick();
    chk("lw_done_state", {29'd0, state}, 32'd0);
    chk("lw_retired", retired, 32'd2);

    // sw 0xAC880004
    instr(6'h2B, 6'h04);
    chk("sw_fetch_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("sw_dec_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    chk("sw_exec_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("sw_mem_state", {29'd0, state}, 32'd3);
    chk("sw_mem_mem_we", {31'd0, mem_we}, 32'd1);
    chk("sw_mem_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    chk("sw_done_state", {29'd0, state}, 32'd0);
    chk("sw_retired", retired, 32'd3);

    // beq taken, then not taken
    instr(6'h04, 6'h00);
    zero = 1'b1;
    tick(); tick();
    chk("beq1_exec_state", {29'd0, state}, 32'd2);
    chk("beq1_pc_we", {31'd0, pc_we}, 32'd1);
    chk("beq1_npc", {30'd0, npc_sel}, 32'd1);
    chk("beq1_aluop", {29'd0, alu_op}, 32'd1);
    chk("beq1_ext", {31'd0, ext_op}, 32'd1);
    tick();
    chk("beq1_retired", retired, 32'd4);
    zero = 1'b0;
    tick(); tick(); #1;
    chk("beq0_pc_we", {31'd0, pc_we}, 32'd0);
    tick();
    chk("beq0_done_state", {29'd0, state}, 32'd0);
    chk("beq0_retired", retired, 32'd5);

    // jal then jr
    instr(6'h03, 6'h00);
    tick();
    chk("jal_reg_we", {31'd0, reg_we}, 32'd1);
    chk("jal_a3", {30'd0, a3_sel}, 32'd2);
    chk("jal_wd", {30'd0, wd_sel}, 32'd2);
    chk("jal_npc", {30'd0, npc_sel}, 32'd2);
    chk("jal_pc_we", {31'd0, pc_we}, 32'd1);
    tick();
    chk("jal_done_state", {29'd0, state}, 32'd0);
    instr(6'h00, 6'h08);
    tick();
    chk("jr_npc", {30'd0, npc_sel}, 32'd3);
    chk("jr_pc_we", {31'd0, pc_we}, 32'd1);
    chk("jr_reg_we", {31'd0, reg_we}, 32'd0);
    tick();
    chk("jr_retired", retired, 32'd7);

    // ori
    instr(6'h0D, 6'h00);
    tick(); tick();
    chk("ori_aluop", {29'd0, alu_op}, 32'd2);
    chk("ori_alub", {30'd0, alu_b_sel}, 32'd1);
    chk("ori_ext", {31'd0, ext_op}, 32'd0);
    tick();
    chk("ori_wb_a3", {30'd0, a3_sel}, 32'd0);
    tick();
    chk("ori_retired", retired, 32'd8);

    // nop retires from DECODE
    instr(6'h00, 6'h00);
    tick();
    chk("nop_illegal", {31'd0, illegal}, 32'd0);
    tick();
    chk("nop_state", {29'd0, state}, 32'd0);
    chk("nop_retired", retired, 32'd9);

    // undecodable opcode 0x3F
    instr(6'h3F, 6'h00);
    tick();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    tick();
    chk("ill_pulse_end", {31'd0, illegal}, 32'd0);
    chk("ill_retired", retired, 32'd10);

    // reset while sw sits in MEM
    instr(6'h2B, 6'h04);
    tick(); tick(); tick();
    chk("swr_mem_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1; #1;
    chk("swr_mem_we_drop", {31'd0, mem_we}, 32'd0);
    chk("swr_state", {29'd0, state}, 32'd0);
    chk("swr_retired", retired, 32'd0);
    tick();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
